// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the memory responder's state type.
// Imported by every AHB peripheral in this slice.
package ahb_pkg;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'b00,
    HT_BUSY   = 2'b01,
    HT_NONSEQ = 2'b10,
    HT_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HS_BYTE = 3'd0,
    HS_HALF = 3'd1,
    HS_WORD = 3'd2
  } hsize_e;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_e;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Maps (HSIZE, addr[1:0]) to little-endian byte-lane strobes.
// Oversized transfers yield no lanes; the caller flags them.
module ahb_byte_strobe
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o,
  output logic       misalign_o
);

  always_comb begin
    strb_o     = 4'b0000;
    misalign_o = 1'b0;
    unique case (1'b1)
      (size_i == HS_BYTE): begin
        strb_o = 4'b0001 << addr_i;
      end
      (size_i == HS_HALF): begin
        strb_o     = 4'b0011 << {addr_i[1], 1'b0};
        misalign_o = addr_i[0];
      end
      (size_i == HS_WORD): begin
        strb_o     = 4'b1111;
        misalign_o = |addr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite responder over a word-organised memory with fixed wait
// states, byte-lane writes and a two-cycle ERROR for bad transfers.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int unsigned AW =
    (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [31:0] MEM_BYTES =
    32'(MEM_DEPTH * 4);
  localparam logic [3:0] WS_LOAD =
    4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [3:0]    strb_q, strb_d;

  logic [31:0]   mem_q [MEM_DEPTH];

  logic [31:0]   offset;
  logic [3:0]    strb;
  logic          misalign;
  logic          accept;
  logic          err;
  logic          we;
  logic          unused_w;

  assign offset = HADDR - BASE_ADDR;
  assign accept = HSEL && HREADY && HTRANS[1];
  assign err    = (offset >= MEM_BYTES)
               || (HSIZE > HS_WORD)
               || misalign;
  assign unused_w = ^{HBURST, HTRANS[0]};

  ahb_byte_strobe u_strb (
    .size_i     (HSIZE),
    .addr_i     (HADDR[1:0]),
    .strb_o     (strb),
    .misalign_o (misalign)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    strb_d    = strb_q;
    HREADYOUT = 1'b1;
    HRESP     = RESP_OKAY;
    unique case (state_q)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 4'd0) state_d = S_LAST;
        else cnt_d = cnt_q - 4'd1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = RESP_ERROR;
        state_d   = S_ERR2;
      end
      default: begin
        if (state_q == S_ERR2) HRESP = RESP_ERROR;
        // Address phase overlaps the last data-phase cycle.
        if (accept) begin
          idx_d  = offset[AW+1:2];
          wr_d   = HWRITE;
          strb_d = strb;
          if (err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_LAST;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end else if (HREADY) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      strb_q  <= strb_d;
    end
  end

  assign we = (state_q == S_LAST) && wr_q
           && HREADY && !HRESET;

  always_ff @(posedge HCLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  assign HRDATA = (state_q == S_LAST && !wr_q)
                ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Randomised bench for ahb_slave_mem against a byte-array bus model.
// Two instances (0 and 2 wait states) share one master.
module tb_ahb_slave_mem;

  typedef struct packed {
    logic        hs;
    logic [1:0]  tr;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
    logic [2:0]  bu;
    logic [31:0] wd;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hsel = 1'b0;
  logic        sel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hsel0, hsel2;
  logic        rdy0, rdy2, rsp0, rsp2;
  logic [31:0] rd0, rd2;

  int total = 0;
  int bad = 0;

  logic [7:0] mb [2][1024];
  xfer_t      xq [$];

  always #5 clk = ~clk;

  assign hsel0 = hsel & ~sel;
  assign hsel2 = hsel & sel;

  ahb_slave_mem #(
    .MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(0)
  ) u_ws0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(rsp0)
  );

  ahb_slave_mem #(
    .MEM_DEPTH(256), .BASE_ADDR(32'h0), .WAIT_STATES(2)
  ) u_ws2 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel2), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize),
    .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy2),
    .HRDATA(rd2), .HREADYOUT(rdy2), .HRESP(rsp2)
  );

  function automatic bit is_err(input xfer_t x);
    logic [31:0] a;
    a = x.addr;
    return (a >= 32'd1024) || (x.sz > 3'd2)
        || (x.sz == 3'd1 && a[0])
        || (x.sz == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input int s, input int a);
    int w;
    w = a & ~3;
    return {mb[s][w+3], mb[s][w+2], mb[s][w+1], mb[s][w]};
  endfunction

  task automatic model_write(input int s, input xfer_t x);
    int n, a;
    n = 1 << x.sz;
    for (int b = 0; b < n; b++) begin
      a = int'(x.addr) + b;
      mb[s][a] = x.wd[8*(a%4) +: 8];
    end
  endtask

  task automatic push(input logic [1:0] tr, input int a,
                      input logic wr, input int sz,
                      input logic [31:0] wd, input logic hs = 1'b1);
    xfer_t x;
    x.hs = hs; x.tr = tr; x.addr = a; x.wr = wr;
    x.sz = 3'(sz); x.bu = 3'd1; x.wd = wd;
    xq.push_back(x);
  endtask

  task automatic finish_up();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic run_seq(input string nm);
    xfer_t dp, ap;
    bit dp_v, dp_e;
    int i, dcyc, ws, s;
    logic e_rdy, e_rsp, o_rdy, o_rsp;
    logic [31:0] e_rd, o_rd;
    dp_v = 0; dp_e = 0; i = 0; dcyc = 0; dp = '0;
    s = sel ? 1 : 0;
    ws = sel ? 2 : 0;
    while (i < xq.size() || dp_v) begin
      ap = (i < xq.size()) ? xq[i] : '0;
      hsel = ap.hs; htrans = ap.tr; haddr = ap.addr;
      hwrite = ap.wr; hsize = ap.sz; hburst = ap.bu;
      hwdata = dp_v ? dp.wd : 32'h0;
      @(negedge clk);
      e_rdy = 1'b1; e_rsp = 1'b0; e_rd = 32'h0;
      if (dp_v && dp_e) begin
        e_rdy = (dcyc != 0);
        e_rsp = 1'b1;
      end else if (dp_v) begin
        e_rdy = (dcyc >= ws);
        if (e_rdy && !dp.wr) e_rd = model_read(s, int'(dp.addr));
      end
      o_rdy = sel ? rdy2 : rdy0;
      o_rsp = sel ? rsp2 : rsp0;
      o_rd  = sel ? rd2 : rd0;
      total++;
      if (o_rdy !== e_rdy) begin
        bad++;
        $display("FAIL %s hreadyout a=%h cyc=%0d got=%b exp=%b",
                 nm, dp.addr, dcyc, o_rdy, e_rdy);
      end
      total++;
      if (o_rsp !== e_rsp) begin
        bad++;
        $display("FAIL %s hresp a=%h cyc=%0d got=%b exp=%b",
                 nm, dp.addr, dcyc, o_rsp, e_rsp);
      end
      total++;
      if (o_rd !== e_rd) begin
        bad++;
        $display("FAIL %s hrdata a=%h cyc=%0d got=%h exp=%h",
                 nm, dp.addr, dcyc, o_rd, e_rd);
      end
      @(posedge clk);
      if (o_rdy) begin
        if (dp_v && !dp_e && dp.wr) model_write(s, dp);
        dp_v = ap.hs && ap.tr[1];
        dp_e = is_err(ap);
        dp = ap;
        dcyc = 0;
        if (i < xq.size()) i++;
      end else begin
        dcyc++;
        if (dcyc > 20) begin
          bad++;
          $display("FAIL %s timeout a=%h got=stuck exp=ready",
                   nm, dp.addr);
          finish_up();
        end
      end
      #1;
    end
    xq.delete();
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (rdy0 !== 1'b1 || rdy2 !== 1'b1) begin
      bad++;
      $display("FAIL reset hreadyout got=%b%b exp=11", rdy0, rdy2);
    end
    if (rsp0 !== 1'b0 || rsp2 !== 1'b0) begin
      bad++;
      $display("FAIL reset hresp got=%b%b exp=00", rsp0, rsp2);
    end
    if (rd0 !== 32'h0) begin
      bad++;
      $display("FAIL reset hrdata0 got=%h exp=0", rd0);
    end
    if (rd2 !== 32'h0) begin
      bad++;
      $display("FAIL reset hrdata2 got=%h exp=0", rd2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_init();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int w = 0; w < 256; w++)
        push(w == 0 ? 2'b10 : 2'b11, w*4, 1'b1, 2, $urandom);
      run_seq("init");
    end
  endtask

  task automatic test_word_rw();
    sel = 1'b0;
    push(2'b10, 32'h10, 1'b1, 2, 32'hDEAD_BEEF);
    push(2'b10, 32'h10, 1'b0, 2, 32'h0);
    run_seq("word_rw");
    total++;
    if (model_read(0, 32'h10) !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL word_rw model got=%h exp=deadbeef",
               model_read(0, 32'h10));
    end
  endtask

  task automatic test_byte_half();
    sel = 1'b0;
    push(2'b10, 32'h10, 1'b1, 2, 32'h1122_3344);
    push(2'b10, 32'h13, 1'b1, 0, 32'hA500_0000);
    push(2'b10, 32'h10, 1'b0, 2, 32'h0);
    push(2'b10, 32'h12, 1'b1, 1, 32'h5A5A_0000);
    push(2'b10, 32'h10, 1'b0, 2, 32'h0);
    run_seq("byte_half");
  endtask

  task automatic test_burst_ws2();
    sel = 1'b1;
    for (int b = 0; b < 4; b++)
      push(b == 0 ? 2'b10 : 2'b11, b*4, 1'b1, 2, $urandom);
    for (int b = 0; b < 4; b++)
      push(b == 0 ? 2'b10 : 2'b11, b*4, 1'b0, 2, 32'h0);
    push(2'b10, 32'h40, 1'b1, 2, $urandom);
    push(2'b01, 32'h44, 1'b1, 2, 32'hFFFF_FFFF);
    push(2'b11, 32'h44, 1'b1, 2, $urandom);
    push(2'b10, 32'h40, 1'b0, 2, 32'h0);
    push(2'b11, 32'h44, 1'b0, 2, 32'h0);
    run_seq("burst_ws2");
  endtask

  task automatic test_errors();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      push(2'b10, 32'h400, 1'b0, 2, 32'h0);
      push(2'b10, 32'h2, 1'b1, 2, 32'hBAD0_0001);
      push(2'b10, 32'h5, 1'b1, 1, 32'hBAD0_0002);
      push(2'b10, 32'h8, 1'b1, 3, 32'hBAD0_0003);
      push(2'b10, 32'h404, 1'b1, 2, 32'hBAD0_0004);
      push(2'b10, 32'h0, 1'b0, 2, 32'h0);
      push(2'b10, 32'h4, 1'b0, 2, 32'h0);
      push(2'b10, 32'h8, 1'b0, 2, 32'h0);
      run_seq("errors");
    end
  endtask

  task automatic test_back_to_back();
    int a;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 10; k++) begin
        a = $urandom_range(0, 255) * 4;
        push(2'b10, a, 1'b1, 2, $urandom);
        push(2'b11, a, 1'b0, 2, 32'h0);
      end
      run_seq("back_to_back");
    end
  endtask

  task automatic test_random();
    int a, sz, r;
    logic [1:0] tr;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 300; k++) begin
        sz = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
        a = $urandom_range(0, 1023);
        if (sz < 3 && $urandom_range(0, 3) != 0)
          a = a & ~((1 << sz) - 1);
        if ($urandom_range(0, 15) == 0)
          a = a + 1024 * $urandom_range(1, 4);
        r = $urandom_range(0, 9);
        tr = (r == 0) ? 2'b00 : (r == 1) ? 2'b01
           : (r < 6) ? 2'b10 : 2'b11;
        push(tr, a, $urandom_range(0, 1) == 1, sz, $urandom,
             $urandom_range(0, 9) != 0);
      end
      run_seq("random");
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20;
    hwrite = 1'b1; hsize = 3'd2; hburst = 3'd0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    hwdata = 32'hCAFE_F00D;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (rdy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid wait got=%b exp=0", rdy2);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total += 3;
    if (rdy2 !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid hreadyout got=%b exp=1", rdy2);
    end
    if (rsp2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid hresp got=%b exp=0", rsp2);
    end
    if (rd2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid hrdata got=%h exp=0", rd2);
    end
    @(posedge clk); #1;
    push(2'b10, 32'h20, 1'b0, 2, 32'h0);
    push(2'b10, 32'h10, 1'b0, 2, 32'h0);
    run_seq("reset_mid");
  endtask

  initial begin
    test_reset();
    test_init();
    test_word_rw();
    test_byte_half();
    test_burst_ws2();
    test_errors();
    test_back_to_back();
    test_random();
    test_reset_mid();
    finish_up();
  end

endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

AHB-Lite responder backed by a word-organised on-chip memory, sitting on the other end of the bus driven by our pipelined ALU/register-file AHB master. It accepts single and incrementing-burst transfers (IDLE/BUSY/NONSEQ/SEQ), inserts a configurable number of wait states, and performs byte/halfword/word writes using byte lanes. Out-of-range, misaligned or oversized transfers get the standard two-cycle ERROR response with no memory side effect.

## Interface
Parameters:
- MEM_DEPTH, 256, number of 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15).

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  slave select from the decoder.
- HADDR  in  32  byte address (address phase).
- HTRANS  in  2  transfer type.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  transfer size; 0 = byte, 1 = half, 2 = word.
- HBURST  in  3  burst type; informational only.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-level ready; tied to HREADYOUT in single-slave systems.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Accept: address phase sampled when HSEL && HREADY && HTRANS[1]; latches offset (HADDR-BASE_ADDR), HWRITE, HSIZE into data-phase registers.
- IDLE/BUSY, or HSEL low: no access; zero-wait OKAY response in the following cycle.
- Error check at accept: offset >= MEM_DEPTH*4, HSIZE > 2, HSIZE=1 with addr[0]=1, HSIZE=2 with addr[1:0]!=0.
- States: S_IDLE (HREADYOUT=1, HRESP=0), S_WAIT (HREADYOUT=0, HRESP=0, counter decrements), S_LAST (HREADYOUT=1, HRESP=0, access completes), S_ERR1 (HREADYOUT=0, HRESP=1), S_ERR2 (HREADYOUT=1, HRESP=1).
- Transitions on accept from S_IDLE/S_LAST/S_ERR2: error -> S_ERR1; WAIT_STATES=0 -> S_LAST; else S_WAIT with counter=WAIT_STATES-1. S_WAIT -> S_LAST when counter=0. S_ERR1 -> S_ERR2 always. S_LAST/S_ERR2 with no accept -> S_IDLE.
- Write: in S_LAST, HWDATA lanes enabled by strobe (byte: lane addr[1:0]; half: lanes {addr[1],0}+1..; word: all 4) written to mem[offset[..:2]] at the clock edge ending S_LAST. Little-endian.
- Read: in S_LAST, HRDATA = full word mem[offset[..:2]] (combinational from data-phase register); otherwise HRDATA=0.
- Error transfers: no memory write, HRDATA=0.
- Write followed by read of same word back-to-back: read returns newly written data (write commits before next data phase).
- Reset mid-operation: state -> S_IDLE, counters cleared, pending transfer dropped; memory contents retained.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0.
- OKAY latency: data phase lasts WAIT_STATES+1 cycles after the accept edge.
- ERROR: exactly two data-phase cycles, HRESP high in both, HREADYOUT low in the first.
- Pipelining: next address phase overlaps the current S_LAST/S_ERR2 cycle; back-to-back zero-wait bursts sustain one transfer per cycle.
- HREADY low (other slave stalling): no accept; state held only if not in S_WAIT/S_ERR1, which always advance.

## Structure
- Shared package ahb_pkg: HTRANS codes (IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11), HSIZE codes, HRESP codes, slave state enum.
- Sub-module ahb_byte_strobe: (HSIZE, addr[1:0]) -> 4-bit lane strobe plus misaligned flag; reused by future peripherals.
- Memory is a plain reg array inside the block; no reset of its contents.

## Test plan
- WAIT_STATES=0: word write 32'hDEAD_BEEF to 0x10, then read 0x10 -> HRDATA=32'hDEAD_BEEF, HREADYOUT never low, HRESP=0.
- Byte write 8'hA5 to 0x13 over word 32'h1122_3344 -> readback 32'hA522_3344; half write 16'h5A5A to 0x12 -> 32'h5A5A_3344.
- WAIT_STATES=2: 4-beat INCR write 0x0..0xC -> each beat HREADYOUT low 2 cycles; NONSEQ,BUSY,SEQ sequence -> BUSY gets zero-wait OKAY, no write.
- Read 0x400 with MEM_DEPTH=256 and word write to 0x2 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, memory unchanged.
- HRESET asserted in S_WAIT -> next cycle HREADYOUT=1, HRESP=0, HRDATA=0; pending write not committed; prior data intact.
